vx_fp_packer: RTL and testbench
===============================

Name:
vx_fp_packer

Overview:
- Inverse of the FPU operand classifier: takes an unpacked value (sign, wide signed biased exponent, mantissa with hidden bit, special-class flags) and packs it into an IEEE-754 bit pattern.
- Emits canonical NaN, infinities, zeros, subnormals and normals, and raises NV/OF/UF flags.
- Two-stage elastic pipeline with valid/ready handshake; sits at the tail of DSP-style FPU units after rounding.

Parameters:
- EXP_BITS, 8, exponent field width.
- MAN_BITS, 23, stored mantissa width (excludes hidden bit).
- TAG_WIDTH, 8, sideband tag carried alongside the data.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- valid_in  input  1  input transaction valid.
- ready_in  output  1  block can accept input.
- sign_in  input  1  sign.
- exp_in  input  EXP_BITS+2  signed two's-complement biased exponent.
- man_in  input  MAN_BITS+1  mantissa; bit MAN_BITS is the hidden bit.
- clss_in  input  fclass_t  special-case flags: is_zero, is_inf, is_nan, is_signaling used; other fields ignored.
- tag_in  input  TAG_WIDTH  sideband.
- valid_out  output  1  result valid.
- ready_out  input  1  downstream accepts result.
- result_out  output  1+EXP_BITS+MAN_BITS  packed value {sign, exp, man}.
- fflags_out  output  3  {NV, OF, UF}.
- tag_out  output  TAG_WIDTH  sideband, aligned with result_out.

Behaviour:
- Reset: both stage valids = 0. valid_out = 0, result_out = 0, fflags_out = 0, tag_out = 0. Reset wins over any simultaneous handshake and discards in-flight data.
- Handshake:
  - Input transfer when valid_in & ready_in. Output transfer when valid_out & ready_out.
  - Each stage loads when it is empty or the next stage advances in the same cycle.
  - ready_in = ~s0_valid | s1_advance, where s1_advance = ~valid_out | ready_out.
  - Latency is 2 cycles (input accepted in cycle N produces valid_out in N+2). Throughput is 1 per cycle, capacity 2 entries.
  - Outputs are held stable while valid_out & ~ready_out. Order is preserved, with no drops and no duplicates.
- Stage 0 (registered) selects the case, in priority order:
  - NAN if clss_in.is_nan.
  - INF if is_inf.
  - ZERO if is_zero.
  - OVF if exp_in >= 2^EXP_BITS-1 (signed compare).
  - SUB if exp_in <= 0.
  - otherwise NORM.
- Stage 0 also computes shift = 1 - exp_in for SUB, saturated to MAN_BITS+1, and registers sign, mantissa, tag and case.
- Stage 1 (registered) packs the result:
  - NAN: result = canonical quiet NaN {0, all-ones, 1, zeros}, regardless of sign_in. NV = is_signaling.
  - INF: {sign, all-ones, 0}.
  - ZERO: {sign, 0, 0}.
  - OVF: {sign, all-ones, 0}, OF = 1.
  - SUB: man = (man_in >> shift)[MAN_BITS-1:0], exp field 0, truncation only. UF = 1 iff any shifted-out bit is nonzero. If the shifted mantissa is all zero, the result is a signed zero and UF = 1 when man_in != 0.
  - NORM: {sign, exp_in[EXP_BITS-1:0], man_in[MAN_BITS-1:0]}, no flags. The hidden bit is ignored; upstream guarantees normalization.
- Flags not listed for a case are 0. Exactly one case is active per entry.

Test Plan:
- FP32, sign 0, exp_in 127, man_in 0x800000, no class flags -> result 0x3F800000, fflags 0, valid_out exactly 2 cycles after accept.
- exp_in 255, man_in 0x800000, sign 1 -> 0xFF800000, OF = 1. Same with exp_in 300 -> identical.
- exp_in -1, man_in 0x800000 -> 0x00200000, UF = 0. exp_in -1, man_in 0x800001 -> 0x00200000, UF = 1.
- is_nan & is_signaling, sign 1, any payload -> 0x7FC00000, NV = 1. Quiet NaN -> 0x7FC00000, NV = 0. is_zero with sign 1 -> 0x80000000.
- Backpressure: stream tags 1..5 back-to-back, ready_out low for cycles 3-6 -> ready_in drops after 2 entries are held, outputs stay stable while stalled, tags emerge 1..5 in order with none lost.
- Reset asserted while 2 entries are in flight -> next cycle valid_out = 0 and all outputs 0. After release, a new input emerges 2 cycles later and no stale entries appear.

Source files
------------

// File: rtl/vx_fp_packer.sv
// vx_fp_packer: packs an unpacked floating-point value into an IEEE-754 bit pattern.
//
// Takes sign, a wide signed biased exponent, a mantissa with explicit hidden bit
// and special-class flags. Produces canonical NaN, infinities, zeros, subnormals
// (truncated) and normals, with {NV, OF, UF} exception flags.
// Two-stage elastic pipeline with a valid/ready handshake on both sides.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   valid_in / ready_in         upstream handshake
//   sign_in, exp_in, man_in     unpacked operand (exp_in signed, man_in[MAN_BITS] = hidden bit)
//   clss_in                     class flags (is_zero, is_inf, is_nan, is_signaling used)
//   tag_in                      sideband carried with the data
//   valid_out / ready_out       downstream handshake
//   result_out                  packed {sign, exp, man}
//   fflags_out                  {NV, OF, UF}
//   tag_out                     sideband aligned with result_out

package vx_fp_pkg;
    typedef struct packed {
        logic is_normal;
        logic is_subnormal;
        logic is_zero;
        logic is_inf;
        logic is_nan;
        logic is_signaling;
        logic is_quiet;
        logic is_boxed;
    } fclass_t;
endpackage

module vx_fp_packer
    import vx_fp_pkg::*;
#(
    parameter int EXP_BITS  = 8,
    parameter int MAN_BITS  = 23,
    parameter int TAG_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         valid_in,
    output logic                         ready_in,
    input  logic                         sign_in,
    input  logic [EXP_BITS+1:0]          exp_in,
    input  logic [MAN_BITS:0]            man_in,
    input  fclass_t                      clss_in,
    input  logic [TAG_WIDTH-1:0]         tag_in,
    output logic                         valid_out,
    input  logic                         ready_out,
    output logic [EXP_BITS+MAN_BITS:0]   result_out,
    output logic [2:0]                   fflags_out,
    output logic [TAG_WIDTH-1:0]         tag_out
);

    localparam int EW = EXP_BITS + 2;
    localparam int SW = $clog2(MAN_BITS + 2);
    localparam int RW = 1 + EXP_BITS + MAN_BITS;

    localparam logic [EW-1:0] EXP_MAX = {2'b00, {EXP_BITS{1'b1}}};

    typedef enum logic [2:0] {
        C_NORM, C_SUB, C_OVF, C_ZERO, C_INF, C_NAN
    } case_e;

    // ---------------- stage 0: classify ----------------
    logic                  s0_valid_q;
    case_e                 s0_case_q, s0_case_d;
    logic                  s0_sign_q;
    logic [EXP_BITS-1:0]   s0_exp_q;
    logic [MAN_BITS:0]     s0_man_q;
    logic [SW-1:0]         s0_shift_q, s0_shift_d;
    logic                  s0_snan_q;
    logic [TAG_WIDTH-1:0]  s0_tag_q;

    logic                  s1_advance;
    logic [EW:0]           shift_full;

    assign s1_advance = ~valid_out | ready_out;
    assign ready_in   = ~s0_valid_q | s1_advance;

    // Sign-extend by one bit so 1 - exp_in cannot wrap for the most negative exponent.
    assign shift_full = (EW+1)'(1) - {exp_in[EW-1], exp_in};

    always_comb begin
        s0_case_d = C_NORM;
        if (clss_in.is_nan)                              s0_case_d = C_NAN;
        else if (clss_in.is_inf)                         s0_case_d = C_INF;
        else if (clss_in.is_zero)                        s0_case_d = C_ZERO;
        else if ($signed(exp_in) >= $signed(EXP_MAX))    s0_case_d = C_OVF;
        else if ($signed(exp_in) <= $signed(EW'(0)))     s0_case_d = C_SUB;

        // Shifting by MAN_BITS+1 already clears the whole mantissa, so saturate there.
        if ($signed(shift_full) > $signed((EW+1)'(MAN_BITS + 1)))
            s0_shift_d = SW'(MAN_BITS + 1);
        else
            s0_shift_d = shift_full[SW-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s0_valid_q <= 1'b0;
        end else if (ready_in) begin
            s0_valid_q <= valid_in;
        end
        if (valid_in && ready_in) begin
            s0_case_q  <= s0_case_d;
            s0_sign_q  <= sign_in;
            s0_exp_q   <= exp_in[EXP_BITS-1:0];
            s0_man_q   <= man_in;
            s0_shift_q <= s0_shift_d;
            s0_snan_q  <= clss_in.is_signaling;
            s0_tag_q   <= tag_in;
        end
    end

    // ---------------- stage 1: pack ----------------
    logic                  valid_out_q;
    logic [RW-1:0]         result_q, result_d;
    logic [2:0]            fflags_q, fflags_d;
    logic [TAG_WIDTH-1:0]  tag_q;

    logic [MAN_BITS:0]     sub_kept;
    logic [MAN_BITS:0]     sub_mask;
    logic                  sub_lost;

    assign sub_kept = s0_man_q >> s0_shift_q;
    assign sub_mask = ~({(MAN_BITS+1){1'b1}} << s0_shift_q);
    assign sub_lost = |(s0_man_q & sub_mask);

    always_comb begin
        result_d = {s0_sign_q, s0_exp_q, s0_man_q[MAN_BITS-1:0]};
        fflags_d = 3'b000;
        case (s0_case_q)
            C_NAN: begin
                result_d    = {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MAN_BITS-1){1'b0}}};
                fflags_d[2] = s0_snan_q;
            end
            C_INF:  result_d = {s0_sign_q, {EXP_BITS{1'b1}}, {MAN_BITS{1'b0}}};
            C_ZERO: result_d = {s0_sign_q, {EXP_BITS{1'b0}}, {MAN_BITS{1'b0}}};
            C_OVF: begin
                result_d    = {s0_sign_q, {EXP_BITS{1'b1}}, {MAN_BITS{1'b0}}};
                fflags_d[1] = 1'b1;
            end
            C_SUB: begin
                // Shift is at least 1 here, so the hidden-bit position of sub_kept is always 0.
                result_d    = {s0_sign_q, {EXP_BITS{1'b0}}, sub_kept[MAN_BITS-1:0]};
                fflags_d[0] = sub_lost;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out_q <= 1'b0;
            result_q    <= '0;
            fflags_q    <= '0;
            tag_q       <= '0;
        end else if (s1_advance) begin
            valid_out_q <= s0_valid_q;
            if (s0_valid_q) begin
                result_q <= result_d;
                fflags_q <= fflags_d;
                tag_q    <= s0_tag_q;
            end
        end
    end

    assign valid_out  = valid_out_q;
    assign result_out = result_q;
    assign fflags_out = fflags_q;
    assign tag_out    = tag_q;

    logic unused_bits;
    assign unused_bits = ^{clss_in.is_normal, clss_in.is_subnormal, clss_in.is_quiet,
                           clss_in.is_boxed, sub_kept[MAN_BITS]};

endmodule

// File: tb/tb_vx_fp_packer.sv
module tb_vx_fp_packer;
    import vx_fp_pkg::*;

    logic        clk, reset;
    logic        valid_in, ready_in, sign_in;
    logic [9:0]  exp_in;
    logic [23:0] man_in;
    fclass_t     clss_in;
    logic [7:0]  tag_in;
    logic        valid_out, ready_out;
    logic [31:0] result_out;
    logic [2:0]  fflags_out;
    logic [7:0]  tag_out;

    vx_fp_packer #(.EXP_BITS(8), .MAN_BITS(23), .TAG_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
        .sign_in(sign_in), .exp_in(exp_in), .man_in(man_in), .clss_in(clss_in),
        .tag_in(tag_in), .valid_out(valid_out), .ready_out(ready_out),
        .result_out(result_out), .fflags_out(fflags_out), .tag_out(tag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  fl;
        logic [7:0]  tag;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   rmode = 0;
    int   bp_base = 0;
    bit   saw_rin_low = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference model: IEEE packing from the rules, using integer arithmetic.
    function automatic exp_t ref_pack(bit s, int e, longint m, bit nan, bit snan,
                                      bit inf, bit zero, logic [7:0] tag);
        exp_t   r;
        int     sh;
        longint div;
        r.tag = tag;
        r.fl  = 3'b000;
        if (nan) begin
            r.res = 32'h7FC0_0000;
            r.fl[2] = snan;
        end else if (inf) begin
            r.res = {s, 8'hFF, 23'h0};
        end else if (zero) begin
            r.res = {s, 31'h0};
        end else if (e >= 255) begin
            r.res = {s, 8'hFF, 23'h0};
            r.fl[1] = 1'b1;
        end else if (e <= 0) begin
            sh = 1 - e;
            if (sh > 40) sh = 40;
            div = longint'(1) << sh;
            r.res = {s, 8'h00, 23'(m / div)};
            r.fl[0] = (m % div) != 0;
        end else begin
            r.res = {s, 8'(e), 23'(m)};
        end
        return r;
    endfunction

    // Downstream ready generator.
    initial begin
        ready_out = 1'b1;
        forever begin
            @(negedge clk);
            case (rmode)
                0: ready_out = 1'b1;
                1: ready_out = ($urandom_range(0, 3) != 0);
                2: ready_out = !((cyc - bp_base) >= 3 && (cyc - bp_base) <= 6);
                default: ready_out = 1'b0;
            endcase
        end
    end

    // Monitor: occupancy-based ready_in check, stall stability, scoreboard compare.
    initial begin
        bit          prev_stall;
        logic [31:0] p_res;
        logic [2:0]  p_fl;
        logic [7:0]  p_tag;
        exp_t        e;
        prev_stall = 0;
        p_res = '0; p_fl = '0; p_tag = '0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                prev_stall = 0;
            end else begin
                chk("ready_in_vs_occupancy", 32'(ready_in),
                    32'(!(sb.size() >= 2 && !ready_out)));
                if (!ready_in) saw_rin_low = 1;
                if (prev_stall) begin
                    chk("stall_valid", 32'(valid_out), 32'd1);
                    chk("stall_result", result_out, p_res);
                    chk("stall_fflags", 32'(fflags_out), 32'(p_fl));
                    chk("stall_tag", 32'(tag_out), 32'(p_tag));
                end
                if (valid_out && ready_out) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_output_tag", 32'(tag_out), 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        chk("result", result_out, e.res);
                        chk("fflags", 32'(fflags_out), 32'(e.fl));
                        chk("tag", 32'(tag_out), 32'(e.tag));
                    end
                end
                prev_stall = valid_out && !ready_out;
                p_res = result_out; p_fl = fflags_out; p_tag = tag_out;
            end
        end
    end

    // Drive one transaction; returns #1 after the accepting clock edge.
    task automatic send(input bit s, input int e, input logic [23:0] m, input bit nan,
                        input bit snan, input bit inf, input bit zero,
                        input logic [7:0] tag, input logic [3:0] junk);
        int  w;
        bit  done;
        @(negedge clk);
        sign_in  = s;
        exp_in   = 10'(e);
        man_in   = m;
        clss_in  = '{is_normal: junk[3], is_subnormal: junk[2], is_zero: zero, is_inf: inf,
                     is_nan: nan, is_signaling: snan, is_quiet: junk[1], is_boxed: junk[0]};
        tag_in   = tag;
        valid_in = 1'b1;
        w = 0;
        done = 0;
        while (!done) begin
            #2;
            if (ready_in) begin
                sb.push_back(ref_pack(s, e, longint'(m), nan, snan, inf, zero, tag));
                done = 1;
            end else if (w > 100) begin
                chk("accept_timeout", 32'd0, 32'd1);
                done = 1;
            end else begin
                w++;
                @(negedge clk);
            end
        end
        @(posedge clk);
        #1 valid_in = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 300) begin
            @(posedge clk);
            w++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int          e, b;
        logic [23:0] m;
        bit          nan, snan, inf, zero;
        int          c;

        reset = 1'b1; valid_in = 1'b0; sign_in = 1'b0; exp_in = '0; man_in = '0;
        clss_in = '0; tag_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_result", result_out, 32'd0);
        chk("rst_fflags", 32'(fflags_out), 32'd0);
        chk("rst_tag", 32'(tag_out), 32'd0);
        @(negedge clk) reset = 1'b0;
        #1 chk("rst_ready_in", 32'(ready_in), 32'd1);

        // Directed: 1.0 with latency check.
        send(0, 127, 24'h800000, 0, 0, 0, 0, 8'h01, 4'h0);
        chk("lat_edge1_valid", 32'(valid_out), 32'd0);
        @(posedge clk);
        #1 chk("lat_edge2_valid", 32'(valid_out), 32'd1);
        chk("lat_result", result_out, 32'h3F80_0000);
        chk("lat_fflags", 32'(fflags_out), 32'd0);
        send(1, 255, 24'h800000, 0, 0, 0, 0, 8'h02, 4'h0);
        send(1, 300, 24'h800000, 0, 0, 0, 0, 8'h03, 4'h0);
        send(0, -1,  24'h800000, 0, 0, 0, 0, 8'h04, 4'h0);
        send(0, -1,  24'h800001, 0, 0, 0, 0, 8'h05, 4'h0);
        send(1, 50,  24'h9ABCDE, 1, 1, 0, 0, 8'h06, 4'h0);
        send(0, 50,  24'h812345, 1, 0, 0, 0, 8'h07, 4'h0);
        send(1, 0,   24'h000000, 0, 0, 0, 1, 8'h08, 4'h0);
        send(0, -22, 24'hFFFFFF, 0, 0, 0, 0, 8'h09, 4'h0);
        send(1, -23, 24'h800000, 0, 0, 0, 0, 8'h0A, 4'h0);
        send(0, 254, 24'hFFFFFF, 0, 0, 1, 0, 8'h0B, 4'h0);
        send(0, 254, 24'hFFFFFF, 0, 0, 0, 0, 8'h0C, 4'h0);
        drain();

        // Backpressure: five back-to-back, ready_out low for cycles 3..6.
        saw_rin_low = 0;
        bp_base = cyc;
        rmode = 2;
        for (int t = 1; t <= 5; t++)
            send(0, 100 + t, 24'h800000 | 24'(t), 0, 0, 0, 0, 8'(t), 4'h0);
        drain();
        rmode = 0;
        chk("bp_ready_in_dropped", 32'(saw_rin_low), 32'd1);

        // Randomized stream with random backpressure and idle gaps.
        rmode = 1;
        for (int n = 0; n < 400; n++) begin
            b = $urandom_range(0, 9);
            case (b)
                0, 1, 2, 3, 4: e = $urandom_range(1, 254);
                5, 6:          e = -int'($urandom_range(0, 30));
                7:             e = 255 + int'($urandom_range(0, 256));
                8:             e = -int'($urandom_range(25, 512));
                default: begin
                    c = $urandom_range(0, 6);
                    e = (c == 0) ? 0 : (c == 1) ? 1 : (c == 2) ? 254 : (c == 3) ? 255 :
                        (c == 4) ? -22 : (c == 5) ? -23 : -24;
                end
            endcase
            m = 24'($urandom);
            if ($urandom_range(0, 3) != 0) m[23] = 1'b1;
            c = $urandom_range(0, 15);
            nan  = (c == 0) || (c == 3 && $urandom_range(0, 1) == 1);
            inf  = (c == 1) || (c == 3 && $urandom_range(0, 1) == 1);
            zero = (c == 2) || (c == 3);
            snan = $urandom_range(0, 1) == 1;
            send($urandom_range(0, 1) == 1, e, m, nan, snan, inf, zero, 8'($urandom),
                 4'($urandom));
            if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end
        drain();

        // Reset with two entries in flight.
        rmode = 3;
        send(0, 127, 24'h800000, 0, 0, 0, 0, 8'h11, 4'h0);
        send(1, 128, 24'hC00000, 0, 0, 0, 0, 8'h22, 4'h0);
        @(negedge clk);
        #3 chk("full_ready_in_low", 32'(ready_in), 32'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_valid_out", 32'(valid_out), 32'd0);
        chk("mid_rst_result", result_out, 32'd0);
        chk("mid_rst_fflags", 32'(fflags_out), 32'd0);
        chk("mid_rst_tag", 32'(tag_out), 32'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        rmode = 0;
        send(0, 130, 24'hA00000, 0, 0, 0, 0, 8'hAA, 4'h0);
        chk("post_rst_edge1_valid", 32'(valid_out), 32'd0);
        @(posedge clk);
        #1 chk("post_rst_edge2_valid", 32'(valid_out), 32'd1);
        chk("post_rst_tag", 32'(tag_out), 32'hAA);
        drain();
        repeat (5) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
